// File: rtl/alu_multicycle.sv
// Execute-stage ALU: single-cycle logic/arith ops plus an iterative 1-bit/cycle shifter.
// Latency: 1 cycle for non-shift ops and shamt=0; 1+shamt cycles for shifts (max 32).
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE (one op in flight).
module alu_multicycle #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int SHAMT_WIDTH   = $clog2(DATA_WIDTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  input  logic                     Arith,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    ALUResult,
  output logic                     Zero
);

  localparam logic [OPCODE_LENGTH-1:0] OP_AND = OPCODE_LENGTH'(4'b0000);
  localparam logic [OPCODE_LENGTH-1:0] OP_OR  = OPCODE_LENGTH'(4'b0001);
  localparam logic [OPCODE_LENGTH-1:0] OP_ADD = OPCODE_LENGTH'(4'b0010);
  localparam logic [OPCODE_LENGTH-1:0] OP_XOR = OPCODE_LENGTH'(4'b0101);
  localparam logic [OPCODE_LENGTH-1:0] OP_SUB = OPCODE_LENGTH'(4'b0110);
  localparam logic [OPCODE_LENGTH-1:0] OP_SLL = OPCODE_LENGTH'(4'b0111);
  localparam logic [OPCODE_LENGTH-1:0] OP_BEQ = OPCODE_LENGTH'(4'b1000);
  localparam logic [OPCODE_LENGTH-1:0] OP_SLT = OPCODE_LENGTH'(4'b1100);
  localparam logic [OPCODE_LENGTH-1:0] OP_SRX = OPCODE_LENGTH'(4'b1111);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                  state, state_nxt;
  logic [DATA_WIDTH-1:0]   result_q, result_nxt;
  logic                    zero_q;
  logic                    ld_res;
  logic [SHAMT_WIDTH-1:0]  cnt_q, cnt_nxt;
  logic                    left_q, left_nxt;
  logic                    arith_q, arith_nxt;
  logic                    rdy_q;

  logic                    accept;
  logic                    is_shift;
  logic [SHAMT_WIDTH-1:0]  shamt;
  logic [DATA_WIDTH-1:0]   alu_res;
  logic [DATA_WIDTH-1:0]   shift_step;

  // in_ready is registered so it depends on state only and stays low through reset.
  assign in_ready  = rdy_q;
  assign out_valid = (state == S_DONE);
  assign ALUResult = result_q;
  assign Zero      = zero_q;

  assign accept   = in_valid && rdy_q;
  assign shamt    = SrcB[SHAMT_WIDTH-1:0];
  assign is_shift = (Operation == OP_SLL) || (Operation == OP_SRX);

  // Single-cycle datapath for every non-shift operation code.
  always_comb begin
    alu_res = '0;
    case (Operation)
      OP_AND:  alu_res = SrcA & SrcB;
      OP_OR:   alu_res = SrcA | SrcB;
      OP_ADD:  alu_res = SrcA + SrcB;
      OP_XOR:  alu_res = SrcA ^ SrcB;
      OP_SUB:  alu_res = SrcA - SrcB;
      OP_BEQ:  alu_res = {{(DATA_WIDTH-1){1'b0}}, (SrcA == SrcB)};
      OP_SLT:  alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      default: alu_res = '0;
    endcase
  end

  // One-bit step of the iterative shifter, using the direction captured at accept.
  always_comb begin
    if (left_q) begin
      shift_step = {result_q[DATA_WIDTH-2:0], 1'b0};
    end else begin
      shift_step = {(arith_q & result_q[DATA_WIDTH-1]), result_q[DATA_WIDTH-1:1]};
    end
  end

  // Next-state and datapath control; the result register doubles as the shift working register.
  always_comb begin
    state_nxt  = state;
    result_nxt = result_q;
    ld_res     = 1'b0;
    cnt_nxt    = cnt_q;
    left_nxt   = left_q;
    arith_nxt  = arith_q;
    case (state)
      S_IDLE: begin
        if (accept) begin
          ld_res = 1'b1;
          if (is_shift) begin
            result_nxt = SrcA;
            if (shamt != '0) begin
              cnt_nxt   = shamt;
              left_nxt  = (Operation == OP_SLL);
              arith_nxt = Arith;
              state_nxt = S_SHIFT;
            end else begin
              state_nxt = S_DONE;
            end
          end else begin
            result_nxt = alu_res;
            state_nxt  = S_DONE;
          end
        end
      end
      S_SHIFT: begin
        ld_res     = 1'b1;
        result_nxt = shift_step;
        cnt_nxt    = cnt_q - SHAMT_WIDTH'(1);
        if (cnt_q == SHAMT_WIDTH'(1)) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, result/flag and shift-control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      cnt_q    <= '0;
      left_q   <= 1'b0;
      arith_q  <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt_q   <= cnt_nxt;
      left_q  <= left_nxt;
      arith_q <= arith_nxt;
      rdy_q   <= (state_nxt == S_IDLE);
      if (ld_res) begin
        result_q <= result_nxt;
        zero_q   <= (result_nxt == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: directed vectors with hand-computed results.
// Stimulus pushes expected result and due cycle; a negedge monitor pops on handshake.
// Output backpressure is driven explicitly to exercise hold behaviour in DONE.
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  Operation;
  logic        Arith;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUResult;
  logic        Zero;

  alu_multicycle dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Operation (Operation),
    .Arith     (Arith),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALUResult (ALUResult),
    .Zero      (Zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic [31:0] res;
    int          due;
  } exp_t;

  exp_t sb[$];
  bit   seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
  endtask

  // Monitor: compare every presented output against the queue head; pop on handshake.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        if (!seen) begin
          check("latency", 32'(cyc), 32'(sb[0].due));
          seen = 1'b1;
        end
        check("result", ALUResult, sb[0].res);
        check("zero", 32'(Zero), 32'(sb[0].res == 32'd0));
        check("in_ready_low_in_done", 32'(in_ready), 32'd0);
        if (out_ready) begin
          void'(sb.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  // Drive one operation (inputs change 1ns after posedge), then scramble inputs after accept.
  task automatic issue(input logic [3:0] op, input logic ar, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expv, input int lat,
                       input bit track);
    int n = 0;
    while (in_ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (in_ready !== 1'b1) check("accept_timeout", 32'(in_ready), 32'd1);
    Operation = op;
    Arith     = ar;
    SrcA      = a;
    SrcB      = b;
    in_valid  = 1'b1;
    if (track) sb.push_back('{expv, cyc + lat});
    @(posedge clk); #1;
    in_valid  = 1'b0;
    SrcA      = ~a;
    SrcB      = ~b;
    Arith     = ~ar;
    Operation = op ^ 4'hA;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    Operation = 4'h0; Arith = 1'b0; SrcA = '0; SrcB = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_result", ALUResult, 32'd0);
    check("reset_zero", 32'(Zero), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("in_ready_after_reset", 32'(in_ready), 32'd1);

    // Single-cycle operations.
    issue(4'b0010, 1'b0, 32'd5,          32'd7,          32'd12,         1, 1'b1);
    issue(4'b0110, 1'b0, 32'd7,          32'd7,          32'd0,          1, 1'b1);
    issue(4'b0110, 1'b0, 32'd0,          32'd1,          32'hFFFF_FFFF,  1, 1'b1);
    issue(4'b0000, 1'b0, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000,  1, 1'b1);
    issue(4'b0001, 1'b0, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_FFF0,  1, 1'b1);
    issue(4'b0101, 1'b0, 32'h0000_00FF,  32'h0000_000F,  32'h0000_00F0,  1, 1'b1);
    // Shifts (inputs are scrambled by issue() while the shift runs).
    issue(4'b0111, 1'b0, 32'd1,          32'd31,         32'h8000_0000,  32, 1'b1);
    issue(4'b0111, 1'b0, 32'h0000_ABCD,  32'h0000_0020,  32'h0000_ABCD,  1, 1'b1);
    issue(4'b1111, 1'b1, 32'h8000_0000,  32'd4,          32'hF800_0000,  5, 1'b1);
    issue(4'b1111, 1'b0, 32'h8000_0000,  32'd4,          32'h0800_0000,  5, 1'b1);
    // Compares and unknown code.
    issue(4'b1100, 1'b0, 32'hFFFF_FFFF,  32'd1,          32'd1,          1, 1'b1);
    issue(4'b1100, 1'b0, 32'd1,          32'hFFFF_FFFF,  32'd0,          1, 1'b1);
    issue(4'b1000, 1'b0, 32'h0000_1234,  32'h0000_1234,  32'd1,          1, 1'b1);
    issue(4'b1000, 1'b0, 32'h0000_1234,  32'h0000_1235,  32'd0,          1, 1'b1);
    issue(4'b0011, 1'b0, 32'd5,          32'd7,          32'd0,          1, 1'b1);

    // Backpressure: hold out_ready low in DONE, then release.
    n = 0;
    while (in_ready !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    out_ready = 1'b0;
    issue(4'b0010, 1'b0, 32'd3, 32'd4, 32'd7, 1, 1'b1);
    repeat (3) begin
      @(posedge clk); #1;
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_result", ALUResult, 32'd7);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_handshake", 32'(in_ready), 32'd1);
    issue(4'b0010, 1'b0, 32'd1, 32'd1, 32'd2, 1, 1'b1);

    // Reset mid-shift aborts the operation without producing output.
    issue(4'b0111, 1'b0, 32'd1, 32'd20, 32'd0, 21, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_result", ALUResult, 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("abort_in_ready_next", 32'(in_ready), 32'd1);
    issue(4'b0010, 1'b0, 32'd2, 32'd2, 32'd4, 1, 1'b1);

    n = 0;
    while (sb.size() != 0 && n < 200) begin @(posedge clk); n++; end
    check("drain_queue", 32'(sb.size()), 32'd0);
    repeat (40) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
